// File: rtl/cf_ide_pio_engine.sv
// CompactFlash true-IDE PIO cycle engine: timed ATA register cycles behind an
// Avalon slave, with presence debounce and a small control/status register slave.
module cf_ide_pio_engine #(
    parameter int DEBOUNCE_CYCLES = 25000,
    parameter int DEB_W           = 15,
    parameter int SETUP_CYC       = 2,
    parameter int ACTIVE_RST      = 6,
    parameter int RECOVERY_CYC    = 4,
    parameter int IORDY_TIMEOUT   = 1024,
    parameter int TO_W            = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  av_ide_address,
    input  logic        av_ide_chipselect,
    input  logic        av_ide_read,
    input  logic        av_ide_write,
    input  logic [15:0] av_ide_writedata,
    output logic [15:0] av_ide_readdata,
    output logic        av_ide_waitrequest,
    output logic        av_ide_irq,
    input  logic [1:0]  av_ctl_address,
    input  logic        av_ctl_read,
    input  logic        av_ctl_write,
    input  logic [7:0]  av_ctl_writedata,
    output logic [7:0]  av_ctl_readdata,
    output logic        av_ctl_irq,
    output logic [2:0]  addr,
    output logic [1:0]  cs_n,
    output logic        iord_n,
    output logic        iowr_n,
    output logic [15:0] data_out,
    output logic        data_oe,
    input  logic [15:0] data_in,
    input  logic        iordy,
    input  logic        intrq,
    input  logic        detect_n,
    output logic        power,
    output logic        reset_n_cf
);

    localparam int CNT_W = (TO_W > 8) ? TO_W : 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACTIVE,
        S_WAIT_RDY,
        S_DONE,
        S_RECOVER
    } state_t;

    state_t state, state_next;

    logic [DEB_W-1:0] deb_cnt;
    logic             present;
    logic             present_q;

    logic       power_en;
    logic       cf_reset;
    logic       ctl_irq_en;
    logic       iordy_en;
    logic       ide_irq_en;
    logic       timeout_flag;
    logic       timeout_q;
    logic       ctl_irq;
    logic [7:0] active_len;
    logic [7:0] ctl_rdata;
    logic [7:0] ctl_mux;

    logic [CNT_W-1:0] cnt;
    logic [7:0]       cyc_len;
    logic             cyc_wr;
    logic             cyc_cs1;
    logic             aborted;
    logic [2:0]       cyc_addr;
    logic [15:0]      cyc_wdata;
    logic [15:0]      rdata;

    logic request;
    logic accept;
    logic cnt_clr;
    logic capture;
    logic fill_ff;
    logic set_abort;
    logic set_timeout;
    logic strobe;
    logic drive;

    assign request = av_ide_chipselect & (av_ide_read | av_ide_write);

    // Presence: count consecutive low detect_n clocks, saturating at the threshold.
    assign present = (deb_cnt == DEB_W'(DEBOUNCE_CYCLES));

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_cnt <= '0;
        end else if (detect_n) begin
            deb_cnt <= '0;
        end else if (!present) begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    always_comb begin
        ctl_mux = 8'h00;
        unique case (av_ctl_address)
            2'd0:    ctl_mux = {4'b0, ctl_irq_en, cf_reset, power_en, present};
            2'd1:    ctl_mux = {6'b0, iordy_en, ide_irq_en};
            2'd2:    ctl_mux = {7'b0, timeout_flag};
            default: ctl_mux = active_len;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            power_en     <= 1'b0;
            cf_reset     <= 1'b0;
            ctl_irq_en   <= 1'b0;
            iordy_en     <= 1'b0;
            ide_irq_en   <= 1'b0;
            timeout_flag <= 1'b0;
            timeout_q    <= 1'b0;
            present_q    <= 1'b0;
            ctl_irq      <= 1'b0;
            active_len   <= 8'(ACTIVE_RST);
            ctl_rdata    <= 8'h00;
        end else begin
            if (av_ctl_write) begin
                unique case (av_ctl_address)
                    2'd0:    {ctl_irq_en, cf_reset, power_en} <= av_ctl_writedata[3:1];
                    2'd1:    {iordy_en, ide_irq_en} <= av_ctl_writedata[1:0];
                    2'd2:    ;
                    default: active_len <= (av_ctl_writedata == 8'h00) ? 8'h01 : av_ctl_writedata;
                endcase
            end
            if (set_timeout) begin
                timeout_flag <= 1'b1;
            end else if (av_ctl_write && av_ctl_address == 2'd2 && av_ctl_writedata[0]) begin
                timeout_flag <= 1'b0;
            end
            timeout_q <= timeout_flag;
            present_q <= present;
            // A new event wins over a clearing read in the same clock.
            if (ctl_irq_en && ((present != present_q) || (timeout_flag && !timeout_q))) begin
                ctl_irq <= 1'b1;
            end else if (av_ctl_read && av_ctl_address == 2'd0) begin
                ctl_irq <= 1'b0;
            end
            if (av_ctl_read) begin
                ctl_rdata <= ctl_mux;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        cnt_clr     = 1'b0;
        capture     = 1'b0;
        fill_ff     = 1'b0;
        set_abort   = 1'b0;
        set_timeout = 1'b0;
        // Pins are gated by present so a pulled card sees its strobes drop at once.
        drive  = (state != S_IDLE) && !aborted && present;
        strobe = ((state == S_ACTIVE) || (state == S_WAIT_RDY)) && present;
        unique case (state)
            S_IDLE: begin
                if (request) begin
                    accept  = 1'b1;
                    cnt_clr = 1'b1;
                    if (!present) begin
                        fill_ff    = 1'b1;
                        set_abort  = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        state_next = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (!present) begin
                    fill_ff    = 1'b1;
                    set_abort  = 1'b1;
                    state_next = S_DONE;
                end else if (cnt == CNT_W'(SETUP_CYC - 1)) begin
                    cnt_clr    = 1'b1;
                    state_next = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (!present) begin
                    fill_ff    = 1'b1;
                    set_abort  = 1'b1;
                    state_next = S_DONE;
                end else if (cnt == CNT_W'(cyc_len - 8'd1)) begin
                    cnt_clr = 1'b1;
                    if (iordy_en && !iordy) begin
                        state_next = S_WAIT_RDY;
                    end else begin
                        capture    = 1'b1;
                        state_next = S_DONE;
                    end
                end
            end
            S_WAIT_RDY: begin
                if (!present) begin
                    fill_ff    = 1'b1;
                    set_abort  = 1'b1;
                    state_next = S_DONE;
                end else if (iordy) begin
                    capture    = 1'b1;
                    state_next = S_DONE;
                end else if (cnt == CNT_W'(IORDY_TIMEOUT - 1)) begin
                    fill_ff     = 1'b1;
                    set_timeout = 1'b1;
                    state_next  = S_DONE;
                end
            end
            S_DONE: begin
                cnt_clr    = 1'b1;
                state_next = S_RECOVER;
            end
            S_RECOVER: begin
                if (cnt == CNT_W'(RECOVERY_CYC - 1)) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            cyc_wr   <= 1'b0;
            cyc_cs1  <= 1'b0;
            cyc_addr <= 3'd0;
            cyc_len  <= 8'(ACTIVE_RST);
            aborted  <= 1'b0;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else if (state != S_IDLE) begin
                cnt <= cnt + 1'b1;
            end
            // active_len is sampled once per cycle so mid-cycle writes wait for the next one.
            if (accept) begin
                cyc_wr   <= av_ide_write;
                cyc_cs1  <= av_ide_address[3];
                cyc_addr <= av_ide_address[2:0];
                cyc_len  <= active_len;
                aborted  <= set_abort;
            end else if (set_abort) begin
                aborted <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cyc_wdata <= av_ide_writedata;
        end
        if (capture) begin
            rdata <= data_in;
        end else if (fill_ff) begin
            rdata <= 16'hFFFF;
        end
    end

    assign av_ide_waitrequest = request & (state != S_DONE);
    assign av_ide_readdata    = rdata;
    assign av_ide_irq         = ide_irq_en & present & intrq;
    assign av_ctl_readdata    = ctl_rdata;
    assign av_ctl_irq         = ctl_irq;

    assign addr       = cyc_addr;
    assign cs_n       = drive ? (cyc_cs1 ? 2'b01 : 2'b10) : 2'b11;
    assign iord_n     = ~(strobe & ~cyc_wr);
    assign iowr_n     = ~(strobe & cyc_wr);
    assign data_out   = cyc_wdata;
    assign data_oe    = drive & cyc_wr;
    assign power      = power_en & present;
    assign reset_n_cf = ~(cf_reset | reset | ~present);

endmodule

// File: tb/tb_cf_ide_pio_engine.sv
// Directed bench for cf_ide_pio_engine: queued expected read data is popped by a
// monitor on each completed IDE or control read; pin timing is checked inline.
module tb_cf_ide_pio_engine;

    logic        clk;
    logic        reset;
    logic [3:0]  av_ide_address;
    logic        av_ide_chipselect;
    logic        av_ide_read;
    logic        av_ide_write;
    logic [15:0] av_ide_writedata;
    logic [15:0] av_ide_readdata;
    logic        av_ide_waitrequest;
    logic        av_ide_irq;
    logic [1:0]  av_ctl_address;
    logic        av_ctl_read;
    logic        av_ctl_write;
    logic [7:0]  av_ctl_writedata;
    logic [7:0]  av_ctl_readdata;
    logic        av_ctl_irq;
    logic [2:0]  addr;
    logic [1:0]  cs_n;
    logic        iord_n;
    logic        iowr_n;
    logic [15:0] data_out;
    logic        data_oe;
    logic [15:0] data_in;
    logic        iordy;
    logic        intrq;
    logic        detect_n;
    logic        power;
    logic        reset_n_cf;

    cf_ide_pio_engine dut (
        .clk                (clk),
        .reset              (reset),
        .av_ide_address     (av_ide_address),
        .av_ide_chipselect  (av_ide_chipselect),
        .av_ide_read        (av_ide_read),
        .av_ide_write       (av_ide_write),
        .av_ide_writedata   (av_ide_writedata),
        .av_ide_readdata    (av_ide_readdata),
        .av_ide_waitrequest (av_ide_waitrequest),
        .av_ide_irq         (av_ide_irq),
        .av_ctl_address     (av_ctl_address),
        .av_ctl_read        (av_ctl_read),
        .av_ctl_write       (av_ctl_write),
        .av_ctl_writedata   (av_ctl_writedata),
        .av_ctl_readdata    (av_ctl_readdata),
        .av_ctl_irq         (av_ctl_irq),
        .addr               (addr),
        .cs_n               (cs_n),
        .iord_n             (iord_n),
        .iowr_n             (iowr_n),
        .data_out           (data_out),
        .data_oe            (data_oe),
        .data_in            (data_in),
        .iordy              (iordy),
        .intrq              (intrq),
        .detect_n           (detect_n),
        .power              (power),
        .reset_n_cf         (reset_n_cf)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] ide_q[$];
    logic [7:0]  ctl_q[$];
    bit          ctl_pending = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) ctl_pending <= av_ctl_read;

    // Monitor: compare every completed read against the head of its queue.
    always @(negedge clk) begin
        if (av_ide_chipselect && av_ide_read && !av_ide_waitrequest) begin
            if (ide_q.size() == 0) check("ide_unexpected_done", 1, 0);
            else check("ide_readdata", av_ide_readdata, ide_q.pop_front());
        end
        if (ctl_pending) begin
            if (ctl_q.size() == 0) check("ctl_unexpected_read", 1, 0);
            else check("ctl_readdata", av_ctl_readdata, ctl_q.pop_front());
        end
    end

    task automatic ctl_write(input logic [1:0] a, input logic [7:0] d);
        av_ctl_address = a; av_ctl_writedata = d; av_ctl_write = 1'b1;
        @(posedge clk); #1;
        av_ctl_write = 1'b0;
    endtask

    task automatic ctl_read(input logic [1:0] a, input logic [7:0] exp);
        ctl_q.push_back(exp);
        av_ctl_address = a; av_ctl_read = 1'b1;
        @(posedge clk); #1;
        av_ctl_read = 1'b0;
    endtask

    task automatic trail(input int n, output int oe);
        oe = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (data_oe) oe++;
        end
        @(posedge clk); #1;
    endtask

    task automatic xfer(input bit wr, input logic [3:0] a, input logic [15:0] wd,
                        input logic [15:0] exp, output int wcyc, output int strb,
                        output int first, output logic [1:0] cs_f, output logic [2:0] addr_f,
                        output logic [15:0] dout_f, output int wrong, output int oe,
                        output int cs_low);
        int n;
        bit done;
        if (!wr) ide_q.push_back(exp);
        av_ide_address = a; av_ide_writedata = wd;
        av_ide_chipselect = 1'b1; av_ide_read = !wr; av_ide_write = wr;
        wcyc = 0; strb = 0; first = 0; wrong = 0; oe = 0; cs_low = 0;
        cs_f = 2'b11; addr_f = 3'd0; dout_f = 16'h0;
        n = 0; done = 1'b0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
            if ((wr ? iowr_n : iord_n) == 1'b0) begin
                strb++;
                if (first == 0) begin
                    first = n; cs_f = cs_n; addr_f = addr; dout_f = data_out;
                end
            end
            if ((wr ? iord_n : iowr_n) == 1'b0) wrong++;
            if (data_oe) oe++;
            if (cs_n != 2'b11) cs_low++;
            if (av_ide_waitrequest) wcyc++;
            else done = 1'b1;
        end
        if (!done) check("xfer_completion_bound", 0, 1);
        @(posedge clk); #1;
        av_ide_chipselect = 1'b0; av_ide_read = 1'b0; av_ide_write = 1'b0;
    endtask

    initial begin
        int wc, sb, fi, wr_, oe, csl, oe_t;
        logic [1:0]  csf;
        logic [2:0]  adf;
        logic [15:0] dof;
        bit hit;

        reset = 1'b1; detect_n = 1'b1; iordy = 1'b1; intrq = 1'b0; data_in = 16'h0;
        av_ide_address = 4'h0; av_ide_chipselect = 1'b0; av_ide_read = 1'b0;
        av_ide_write = 1'b0; av_ide_writedata = 16'h0;
        av_ctl_address = 2'd0; av_ctl_read = 1'b0; av_ctl_write = 1'b0; av_ctl_writedata = 8'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", cs_n, 2'b11);
        check("rst_iord_n", iord_n, 1);
        check("rst_iowr_n", iowr_n, 1);
        check("rst_data_oe", data_oe, 0);
        check("rst_addr", addr, 0);
        check("rst_power", power, 0);
        check("rst_reset_n_cf", reset_n_cf, 0);
        check("rst_irqs", {av_ide_irq, av_ctl_irq}, 2'b00);
        check("rst_ctl_readdata", av_ctl_readdata, 8'h00);
        @(posedge clk); #1;
        reset = 1'b0;

        ctl_read(2'd1, 8'h00);
        ctl_read(2'd3, 8'h06);
        ctl_read(2'd0, 8'h00);
        ctl_write(2'd0, 8'h0A);
        ctl_write(2'd1, 8'h01);
        intrq = 1'b1; #1;
        check("ide_irq_gated_absent", av_ide_irq, 0);
        intrq = 1'b0;

        // Debounce: a 24999-clock pulse must not qualify; 25000 must.
        detect_n = 1'b0;
        repeat (24999) @(posedge clk);
        #1;
        check("deb_first_pulse", reset_n_cf, 0);
        detect_n = 1'b1;
        @(posedge clk); #1;
        detect_n = 1'b0;
        repeat (24999) @(posedge clk);
        #1;
        check("deb_24999", reset_n_cf, 0);
        @(posedge clk); #1;
        check("deb_25000", reset_n_cf, 1);
        check("power_on", power, 1);
        @(posedge clk); #1;
        check("ctl_irq_presence", av_ctl_irq, 1);
        ctl_read(2'd0, 8'h0B);
        check("ctl_irq_cleared", av_ctl_irq, 0);
        intrq = 1'b1; #1;
        check("ide_irq_present", av_ide_irq, 1);
        intrq = 1'b0;

        // Read 4'h7 with default timing.
        data_in = 16'hA5C3;
        xfer(1'b0, 4'h7, 16'h0, 16'hA5C3, wc, sb, fi, csf, adf, dof, wr_, oe, csl);
        check("rd_wait", wc, 9);
        check("rd_strobe_len", sb, 6);
        check("rd_strobe_start", fi, 4);
        check("rd_cs_n", csf, 2'b10);
        check("rd_addr", adf, 3'd7);
        check("rd_wrong_strobe", wr_, 0);
        check("rd_oe", oe, 0);
        trail(6, oe_t);

        // Writes with active_len=3, then a back-to-back write.
        ctl_write(2'd3, 8'd3);
        xfer(1'b1, 4'hE, 16'h1234, 16'h0, wc, sb, fi, csf, adf, dof, wr_, oe, csl);
        check("wr_wait", wc, 6);
        check("wr_strobe_len", sb, 3);
        check("wr_strobe_start", fi, 4);
        check("wr_cs_n", csf, 2'b01);
        check("wr_addr", adf, 3'd6);
        check("wr_data_out", dof, 16'h1234);
        check("wr_oe", oe, 6);
        check("wr_wrong_strobe", wr_, 0);
        xfer(1'b1, 4'hE, 16'h5678, 16'h0, wc, sb, fi, csf, adf, dof, wr_, oe, csl);
        check("b2b_wait", wc, 10);
        check("b2b_strobe_len", sb, 3);
        check("b2b_data_out", dof, 16'h5678);
        check("b2b_oe", oe, 10);
        trail(6, oe_t);
        check("b2b_oe_recover", oe_t, 4);

        ctl_write(2'd3, 8'd0);
        ctl_read(2'd3, 8'd1);
        ctl_write(2'd3, 8'd6);
        ctl_read(2'd3, 8'd6);

        // IORDY timeout.
        ctl_write(2'd1, 8'h03);
        iordy = 1'b0;
        xfer(1'b0, 4'h0, 16'h0, 16'hFFFF, wc, sb, fi, csf, adf, dof, wr_, oe, csl);
        check("to_wait", wc, 1033);
        check("to_strobe_len", sb, 1030);
        check("ctl_irq_timeout", av_ctl_irq, 1);
        iordy = 1'b1;
        trail(6, oe_t);
        ctl_read(2'd2, 8'h01);
        ctl_read(2'd0, 8'h0B);
        check("ctl_irq_cleared2", av_ctl_irq, 0);
        ctl_write(2'd2, 8'h01);
        ctl_read(2'd2, 8'h00);

        // Card pulled mid-ACTIVE.
        data_in = 16'h0F0F;
        ide_q.push_back(16'hFFFF);
        av_ide_address = 4'h8; av_ide_chipselect = 1'b1; av_ide_read = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk);
            if (!iord_n) hit = 1'b1;
        end
        check("pull_strobe_seen", hit, 1);
        @(posedge clk); #1;
        detect_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("pull_iord_n", iord_n, 1);
        check("pull_cs_n", cs_n, 2'b11);
        check("pull_oe", data_oe, 0);
        check("pull_power", power, 0);
        check("pull_reset_n_cf", reset_n_cf, 0);
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            if (!av_ide_waitrequest) hit = 1'b1;
            else @(negedge clk);
        end
        check("pull_done", hit, 1);
        @(posedge clk); #1;
        av_ide_chipselect = 1'b0; av_ide_read = 1'b0;
        trail(6, oe_t);

        xfer(1'b0, 4'h2, 16'h0, 16'hFFFF, wc, sb, fi, csf, adf, dof, wr_, oe, csl);
        check("absent_wait", wc, 1);
        check("absent_strobe", sb, 0);
        check("absent_cs", csl, 0);
        trail(6, oe_t);

        detect_n = 1'b0;
        repeat (25001) @(posedge clk);
        #1;
        check("represent", reset_n_cf, 1);
        check("ctl_irq_represent", av_ctl_irq, 1);

        // Reset while stalled in WAIT_RDY.
        iordy = 1'b0;
        av_ide_address = 4'h1; av_ide_chipselect = 1'b1; av_ide_read = 1'b1;
        repeat (12) @(negedge clk);
        check("wait_rdy_strobe", iord_n, 0);
        @(posedge clk); #1;
        reset = 1'b1; av_ide_chipselect = 1'b0; av_ide_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst2_iord_n", iord_n, 1);
        check("rst2_cs_n", cs_n, 2'b11);
        check("rst2_oe", data_oe, 0);
        check("rst2_addr", addr, 0);
        check("rst2_power", power, 0);
        check("rst2_reset_n_cf", reset_n_cf, 0);
        check("rst2_ctl_irq", av_ctl_irq, 0);
        check("rst2_waitrequest", av_ide_waitrequest, 0);
        @(posedge clk); #1;
        reset = 1'b0; iordy = 1'b1;
        ctl_read(2'd3, 8'd6);
        ctl_read(2'd1, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("ide_queue_empty", ide_q.size(), 0);
        check("ctl_queue_empty", ctl_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
